// File: rtl/aib_hrdrst_pkg.sv
// Shared definitions for the AIB hard-reset sequencing blocks.
// Holds the sequencer state encoding (visible on the debug port, so the
// encodings are fixed) and small elaboration-time width helpers.
package aib_hrdrst_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_CONF = 3'd1,
        RST_HOLD  = 3'd2,
        M2S       = 3'd3,
        S2M       = 3'd4,
        LINK_UP   = 3'd5,
        ERROR     = 3'd6
    } hrdrst_seq_state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Width needed to hold 0..v, never less than one bit.
    function automatic int width_for(input int v);
        return (v < 2) ? 1 : $clog2(v + 1);
    endfunction

endpackage

// File: rtl/aib_hrdrst_seq.sv
// Hard-reset sequencer for one AIB channel (aux clock domain).
// Qualifies local/remote configuration-done, holds the m2s/s2m handshake
// FSMs in reset, then releases them and starts m2s followed by s2m. Each
// handshake phase is supervised by a timeout; a timeout re-runs the reset
// and both phases up to RETRY_MAX more times before a sticky error.
//
// Ports:
//   i_aux_clk, i_rst_n      aux clock, async active-low reset
//   i_enable                software enable, low forces IDLE
//   i_conf_done             local configuration complete
//   i_sl_conf_done          remote configuration complete (already synced)
//   o_hrdrst_rst_n          registered active-low reset to m2s/s2m FSMs
//   o_m2s_start/i_m2s_done  m2s handshake start level / done level
//   o_s2m_start/i_s2m_done  s2m handshake start level / done level
//   o_link_up               both directions complete
//   o_error                 retries exhausted (sticky until disabled)
//   o_retry_cnt             retries consumed in the current run
//   o_state                 current state, debug
module aib_hrdrst_seq
    import aib_hrdrst_pkg::*;
#(
    parameter int TIMEOUT_CYC     = 65535,
    parameter int RETRY_MAX       = 3,
    parameter int RST_HOLD_CYC    = 16,
    parameter int CONF_STABLE_CYC = 8
) (
    input  logic                            i_aux_clk,
    input  logic                            i_rst_n,
    input  logic                            i_enable,
    input  logic                            i_conf_done,
    input  logic                            i_sl_conf_done,
    output logic                            o_hrdrst_rst_n,
    output logic                            o_m2s_start,
    input  logic                            i_m2s_done,
    output logic                            o_s2m_start,
    input  logic                            i_s2m_done,
    output logic                            o_link_up,
    output logic                            o_error,
    output logic [width_for(RETRY_MAX)-1:0] o_retry_cnt,
    output logic [2:0]                      o_state
);

    localparam int CNT_W = $clog2(max3(TIMEOUT_CYC, RST_HOLD_CYC, CONF_STABLE_CYC) + 1);
    localparam int RC_W  = width_for(RETRY_MAX);

    localparam logic [CNT_W-1:0] L_CONF = CNT_W'(CONF_STABLE_CYC - 1);
    localparam logic [CNT_W-1:0] L_HOLD = CNT_W'(RST_HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] L_TO   = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [RC_W-1:0]  L_RMAX = RC_W'(RETRY_MAX);

    hrdrst_seq_state_e r_state, w_nxt_state;
    logic [CNT_W-1:0]  r_cnt, w_nxt_cnt;
    logic [RC_W-1:0]   r_retry, w_nxt_retry;
    logic              r_rst_n, r_m2s_start, r_s2m_start, r_link_up, r_error;

    logic w_conf_ok, w_cnt_zero, w_phase_done;

    assign w_conf_ok    = i_conf_done & i_sl_conf_done;
    assign w_cnt_zero   = (r_cnt == '0);
    // M2S and S2M share the done/timeout handling; only the done source differs.
    assign w_phase_done = (r_state == S2M) ? i_s2m_done : i_m2s_done;

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cnt   = r_cnt;
        w_nxt_retry = r_retry;
        if (!i_enable) begin
            // Disable overrides every other transition.
            w_nxt_state = IDLE;
            w_nxt_cnt   = '0;
            w_nxt_retry = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_nxt_state = WAIT_CONF;
                    w_nxt_cnt   = L_CONF;
                    w_nxt_retry = '0;
                end
                WAIT_CONF: begin
                    if (!w_conf_ok) begin
                        w_nxt_cnt = L_CONF;
                    end else if (w_cnt_zero) begin
                        w_nxt_state = RST_HOLD;
                        w_nxt_cnt   = L_HOLD;
                    end else begin
                        w_nxt_cnt = r_cnt - CNT_W'(1);
                    end
                end
                RST_HOLD: begin
                    if (w_cnt_zero) begin
                        w_nxt_state = M2S;
                        w_nxt_cnt   = L_TO;
                    end else begin
                        w_nxt_cnt = r_cnt - CNT_W'(1);
                    end
                end
                M2S, S2M: begin
                    // Done is tested first so a done arriving on the last
                    // allowed cycle is not counted as a timeout.
                    if (w_phase_done) begin
                        w_nxt_state = (r_state == M2S) ? S2M : LINK_UP;
                        w_nxt_cnt   = L_TO;
                    end else if (w_cnt_zero) begin
                        if (r_retry == L_RMAX) begin
                            w_nxt_state = ERROR;
                        end else begin
                            // Retry restarts from reset hold; conf stays qualified.
                            w_nxt_state = RST_HOLD;
                            w_nxt_cnt   = L_HOLD;
                            w_nxt_retry = r_retry + RC_W'(1);
                        end
                    end else begin
                        w_nxt_cnt = r_cnt - CNT_W'(1);
                    end
                end
                LINK_UP: begin
                    // A link drop is a fresh bring-up, not a retry.
                    if (!w_conf_ok || !i_m2s_done || !i_s2m_done) begin
                        w_nxt_state = WAIT_CONF;
                        w_nxt_cnt   = L_CONF;
                        w_nxt_retry = '0;
                    end
                end
                ERROR: begin
                    w_nxt_state = ERROR;
                end
                default: begin
                    w_nxt_state = IDLE;
                    w_nxt_cnt   = '0;
                    w_nxt_retry = '0;
                end
            endcase
        end
    end

    // State, counter and all outputs are registered together; outputs are
    // decoded from the next state so they change on the same edge as the
    // state and never glitch.
    always_ff @(posedge i_aux_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_retry     <= '0;
            r_rst_n     <= 1'b0;
            r_m2s_start <= 1'b0;
            r_s2m_start <= 1'b0;
            r_link_up   <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_state     <= w_nxt_state;
            r_cnt       <= w_nxt_cnt;
            r_retry     <= w_nxt_retry;
            r_rst_n     <= (w_nxt_state == M2S) || (w_nxt_state == S2M) ||
                           (w_nxt_state == LINK_UP);
            r_m2s_start <= (w_nxt_state == M2S) || (w_nxt_state == S2M) ||
                           (w_nxt_state == LINK_UP);
            r_s2m_start <= (w_nxt_state == S2M) || (w_nxt_state == LINK_UP);
            r_link_up   <= (w_nxt_state == LINK_UP);
            r_error     <= (w_nxt_state == ERROR);
        end
    end

    assign o_hrdrst_rst_n = r_rst_n;
    assign o_m2s_start    = r_m2s_start;
    assign o_s2m_start    = r_s2m_start;
    assign o_link_up      = r_link_up;
    assign o_error        = r_error;
    assign o_retry_cnt    = r_retry;
    assign o_state        = r_state;

endmodule
